// File: rtl/bbox_crop_engine.sv
// bbox_crop_engine
//   Scans a row-major pixel RAM (one CH x CW pixel per word) for foreground pixels, finds the
//   tight bounding box, then copies that box row-major into an output RAM from word 0.
//
//   Optional feature macro: BBOX_MARGIN_EN. When defined, the box is grown by MARGIN pixels per
//   side (clamped to the image) before the copy. When undefined the tight box is used.
//
// Ports
//   CLOCK_50        clock, rising edge
//   reset           synchronous active-high reset
//   start           one-cycle request, honoured only in IDLE or DONE
//   thresh, invert  foreground test, latched on an accepted start
//   rd_addr/rd_data source RAM port (synchronous, 1-cycle read latency)
//   wr_en/addr/data output RAM write port
//   busy, done      status; done holds until the next accepted start or reset
//   bbox_empty      no foreground found (valid with done)
//   x_min..y_max    final box (valid with done); crop_w/crop_h its size (0 when empty)
module bbox_crop_engine #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned CH     = 3,
  parameter int unsigned CW     = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned MARGIN = 2,
  localparam int unsigned XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int unsigned YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [CW-1:0]     thresh,
  input  logic              invert,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CH*CW-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CH*CW-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              bbox_empty,
  output logic [XW-1:0]     x_min,
  output logic [XW-1:0]     x_max,
  output logic [YW-1:0]     y_min,
  output logic [YW-1:0]     y_max,
  output logic [XW:0]       crop_w,
  output logic [YW:0]       crop_h
);

`ifdef BBOX_MARGIN_EN
  localparam int unsigned MarginEff = MARGIN;
`else
  // Zero margin makes the clamp stage an identity.
  localparam int unsigned MarginEff = MARGIN * 0;
`endif

  typedef enum logic [2:0] {
    StIdle, StScan, StScanDrain, StCopy, StCopyDrain, StDone
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]     thresh_q, thresh_d;
  logic              invert_q, invert_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XW-1:0]     sx_q, sx_d, px_q, px_d, cx_q, cx_d;
  logic [YW-1:0]     sy_q, sy_d, py_q, py_d, cy_q, cy_d;
  logic              pv_q, pv_d;
  logic              found_q, found_d;
  logic [XW-1:0]     bx_min_q, bx_min_d, bx_max_q, bx_max_d;
  logic [YW-1:0]     by_min_q, by_min_d, by_max_q, by_max_d;
  logic [XW-1:0]     x_min_q, x_min_d, x_max_q, x_max_d;
  logic [YW-1:0]     y_min_q, y_min_d, y_max_q, y_max_d;
  logic [XW:0]       crop_w_q, crop_w_d;
  logic [YW:0]       crop_h_q, crop_h_d;
  logic              empty_q, empty_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic          start_ok, fg, last_scan, last_copy;
  logic [XW-1:0] fx_min, fx_max;
  logic [YW-1:0] fy_min, fy_max;
  logic [31:0]   xl, xh, yl, yh;

  assign start_ok  = start && (state_q == StIdle || state_q == StDone);
  assign last_scan = (sx_q == XW'(IMG_W - 1)) && (sy_q == YW'(IMG_H - 1));
  assign last_copy = (cx_q == x_max_q) && (cy_q == y_max_q);

  // Foreground test on the pixel returned for the previous read; equal counts as background.
  always_comb begin
    fg = 1'b0;
    for (int c = 0; c < int'(CH); c++) begin
      if (invert_q) fg = fg | (rd_data[c*CW +: CW] > thresh_q);
      else          fg = fg | (rd_data[c*CW +: CW] < thresh_q);
    end
  end

  // Running bounds including the pixel currently on rd_data.
  always_comb begin
    found_d  = found_q;
    bx_min_d = bx_min_q;
    bx_max_d = bx_max_q;
    by_min_d = by_min_q;
    by_max_d = by_max_q;
    if (pv_q && fg) begin
      found_d = 1'b1;
      if (!found_q) begin
        bx_min_d = px_q;
        bx_max_d = px_q;
        by_min_d = py_q;
        by_max_d = py_q;
      end else begin
        if (px_q < bx_min_q) bx_min_d = px_q;
        if (px_q > bx_max_q) bx_max_d = px_q;
        if (py_q < by_min_q) by_min_d = py_q;
        if (py_q > by_max_q) by_max_d = py_q;
      end
    end
  end

  // Margin expansion done in 32-bit unsigned so the low clamp never wraps.
  always_comb begin
    xl     = 32'(bx_min_d);
    xh     = 32'(bx_max_d);
    yl     = 32'(by_min_d);
    yh     = 32'(by_max_d);
    fx_min = (xl >= MarginEff) ? XW'(xl - MarginEff) : '0;
    fy_min = (yl >= MarginEff) ? YW'(yl - MarginEff) : '0;
    fx_max = (xh + MarginEff > IMG_W - 1) ? XW'(IMG_W - 1) : XW'(xh + MarginEff);
    fy_max = (yh + MarginEff > IMG_H - 1) ? YW'(IMG_H - 1) : YW'(yh + MarginEff);
  end

  // FSM: state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start_ok) state_d = StScan;
      StScan:      if (last_scan) state_d = StScanDrain;
      StScanDrain: state_d = found_d ? StCopy : StDone;
      StCopy:      if (last_copy) state_d = StCopyDrain;
      StCopyDrain: state_d = StDone;
      StDone:      if (start_ok) state_d = StScan;
      default:     state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StScan, StScanDrain, StCopy, StCopyDrain: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state.
  always_comb begin
    thresh_d  = thresh_q;
    invert_d  = invert_q;
    rd_addr_d = rd_addr_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    px_d      = px_q;
    py_d      = py_q;
    pv_d      = 1'b0;
    cx_d      = cx_q;
    cy_d      = cy_q;
    x_min_d   = x_min_q;
    x_max_d   = x_max_q;
    y_min_d   = y_min_q;
    y_max_d   = y_max_q;
    crop_w_d  = crop_w_q;
    crop_h_d  = crop_h_q;
    empty_d   = empty_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          thresh_d  = thresh;
          invert_d  = invert;
          rd_addr_d = '0;
          sx_d      = '0;
          sy_d      = '0;
          x_min_d   = '0;
          x_max_d   = '0;
          y_min_d   = '0;
          y_max_d   = '0;
          crop_w_d  = '0;
          crop_h_d  = '0;
          empty_d   = 1'b0;
          wr_addr_d = '0;
        end
      end
      StScan: begin
        pv_d      = 1'b1;
        px_d      = sx_q;
        py_d      = sy_q;
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        if (sx_q == XW'(IMG_W - 1)) begin
          sx_d = '0;
          sy_d = sy_q + YW'(1);
        end else begin
          sx_d = sx_q + XW'(1);
        end
      end
      StScanDrain: begin
        empty_d = !found_d;
        if (found_d) begin
          x_min_d   = fx_min;
          x_max_d   = fx_max;
          y_min_d   = fy_min;
          y_max_d   = fy_max;
          crop_w_d  = {1'b0, fx_max} - {1'b0, fx_min} + (XW + 1)'(1);
          crop_h_d  = {1'b0, fy_max} - {1'b0, fy_min} + (YW + 1)'(1);
          cx_d      = fx_min;
          cy_d      = fy_min;
          rd_addr_d = ADDR_W'(32'(fy_min) * IMG_W + 32'(fx_min));
        end
      end
      StCopy: begin
        // Write of this read lands next cycle, hence the one-cycle-late address counter.
        wr_en_d   = 1'b1;
        wr_addr_d = wr_en_q ? wr_addr_q + ADDR_W'(1) : '0;
        if (cx_q == x_max_q) begin
          cx_d      = x_min_q;
          cy_d      = cy_q + YW'(1);
          rd_addr_d = ADDR_W'(32'(rd_addr_q) + IMG_W + 1 - 32'(crop_w_q));
        end else begin
          cx_d      = cx_q + XW'(1);
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      thresh_q  <= '0;
      invert_q  <= 1'b0;
      rd_addr_q <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      px_q      <= '0;
      py_q      <= '0;
      pv_q      <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      found_q   <= 1'b0;
      bx_min_q  <= '0;
      bx_max_q  <= '0;
      by_min_q  <= '0;
      by_max_q  <= '0;
      x_min_q   <= '0;
      x_max_q   <= '0;
      y_min_q   <= '0;
      y_max_q   <= '0;
      crop_w_q  <= '0;
      crop_h_q  <= '0;
      empty_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      thresh_q  <= thresh_d;
      invert_q  <= invert_d;
      rd_addr_q <= rd_addr_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      px_q      <= px_d;
      py_q      <= py_d;
      pv_q      <= pv_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      found_q   <= start_ok ? 1'b0 : found_d;
      bx_min_q  <= bx_min_d;
      bx_max_q  <= bx_max_d;
      by_min_q  <= by_min_d;
      by_max_q  <= by_max_d;
      x_min_q   <= x_min_d;
      x_max_q   <= x_max_d;
      y_min_q   <= y_min_d;
      y_max_q   <= y_max_d;
      crop_w_q  <= crop_w_d;
      crop_h_q  <= crop_h_d;
      empty_q   <= empty_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_en_q ? rd_data : '0;
  assign bbox_empty = empty_q;
  assign x_min      = x_min_q;
  assign x_max      = x_max_q;
  assign y_min      = y_min_q;
  assign y_max      = y_max_q;
  assign crop_w     = crop_w_q;
  assign crop_h     = crop_h_q;

endmodule

// File: tb/tb_bbox_crop_engine.sv
// Directed bench for bbox_crop_engine on an 8x8, 3x8-bit image.
module tb_bbox_crop_engine;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset, start, invert;
  logic [7:0]  thresh;
  logic [15:0] rd_addr, wr_addr;
  logic [23:0] rd_data, wr_data;
  logic        wr_en, busy, done, bbox_empty;
  logic [2:0]  x_min, x_max, y_min, y_max;
  logic [3:0]  crop_w, crop_h;

  logic [23:0] img [N];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Synchronous source RAM.
  always @(posedge clk) rd_data <= img[rd_addr[5:0]];

  bbox_crop_engine #(
    .IMG_W(W), .IMG_H(H), .CH(3), .CW(8), .ADDR_W(16), .MARGIN(2)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .thresh(thresh), .invert(invert),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .bbox_empty(bbox_empty),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .crop_w(crop_w), .crop_h(crop_h)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Background: channel 0 = 0x80+i, never below 0x80; every word distinct.
  task automatic fill_bg();
    for (int i = 0; i < N; i++) img[i] = {8'hFF, 8'hFF, 8'(8'h80 + i)};
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " rd_addr"}, 32'(rd_addr), 0);
    chk({tag, " wr_en"}, 32'(wr_en), 0);
    chk({tag, " wr_addr"}, 32'(wr_addr), 0);
    chk({tag, " wr_data"}, 32'(wr_data), 0);
    chk({tag, " empty"}, 32'(bbox_empty), 0);
    chk({tag, " box"}, {20'd0, x_min, x_max, y_min, y_max}, 0);
    chk({tag, " crop"}, {24'd0, crop_w, crop_h}, 0);
  endtask

  // One full operation from the current state. restart_at / mess_at: cycle where start is
  // re-pulsed / thresh and invert are flipped (-1 for never).
  task automatic run_op(input string tag, input int ex0, input int ex1, input int ey0,
                        input int ey1, input bit exp_empty, input int restart_at,
                        input int mess_at);
    int ew, eh, m, exp_done, done_cyc, nwr;
    logic [5:0] idx;
    ew       = exp_empty ? 0 : ex1 - ex0 + 1;
    eh       = exp_empty ? 0 : ey1 - ey0 + 1;
    m        = ew * eh;
    exp_done = exp_empty ? N + 2 : N + m + 3;
    done_cyc = -1;
    nwr      = 0;
    tick();
    start = 1'b1;  // cycle 0
    for (int cyc = 1; cyc <= 400; cyc++) begin
      tick();
      start = (cyc == restart_at);
      if (cyc == mess_at) begin
        thresh = ~thresh;
        invert = ~invert;
      end
      @(negedge clk);
      if (cyc == 1) begin
        chk({tag, " c1 busy"}, 32'(busy), 1);
        chk({tag, " c1 done"}, 32'(done), 0);
        chk({tag, " c1 box"}, {20'd0, x_min, x_max, y_min, y_max}, 0);
        chk({tag, " c1 crop"}, {24'd0, crop_w, crop_h}, 0);
      end
      if (wr_en) begin
        chk({tag, " wr_addr"}, 32'(wr_addr), 32'(nwr));
        if (nwr < m) begin
          idx = 6'((ey0 + nwr / ew) * W + ex0 + nwr % ew);
          chk({tag, " wr_data"}, 32'(wr_data), 32'(img[idx]));
        end
        nwr++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    chk({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, " writes"}, 32'(nwr), 32'(m));
    chk({tag, " busy@done"}, 32'(busy), 0);
    chk({tag, " empty"}, 32'(bbox_empty), 32'(exp_empty));
    chk({tag, " x_min"}, 32'(x_min), 32'(ex0));
    chk({tag, " x_max"}, 32'(x_max), 32'(ex1));
    chk({tag, " y_min"}, 32'(y_min), 32'(ey0));
    chk({tag, " y_max"}, 32'(y_max), 32'(ey1));
    chk({tag, " crop_w"}, 32'(crop_w), 32'(ew));
    chk({tag, " crop_h"}, 32'(crop_h), 32'(eh));
    tick();
    @(negedge clk);
    chk({tag, " done held"}, 32'(done), 1);
    chk({tag, " no write after"}, 32'(wr_en), 0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    thresh = 8'h00;
    invert = 1'b0;
    fill_bg();
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");

    // Single dark pixel at (3,5).
    fill_bg();
    img[5*W+3] = 24'h000000;
    thresh = 8'h80;
    invert = 1'b0;
    run_op("single", 3, 3, 5, 5, 1'b0, -1, -1);

    // No foreground; 0x808080 equals thresh and is background.
    fill_bg();
    img[10] = 24'h808080;
    run_op("empty", 0, 0, 0, 0, 1'b1, -1, -1);

    // Whole image foreground, distinct words to check copy order.
    for (int i = 0; i < N; i++) img[i] = {8'(i), 8'(8'h3F - i), 8'(i ^ 8'h15)};
    run_op("full", 0, 7, 0, 7, 1'b0, -1, -1);

    // Two dark pixels; margin grows the box when enabled.
    fill_bg();
    img[1*W+1] = 24'hFF10FF;
    img[2*W+6] = 24'hFFFF20;
`ifdef BBOX_MARGIN_EN
    run_op("margin", 0, 7, 0, 4, 1'b0, -1, -1);
`else
    run_op("two-px", 1, 6, 1, 2, 1'b0, -1, -1);
`endif

    // Reset asserted during cycle 20 of a scan.
    fill_bg();
    img[5*W+3] = 24'h000000;
    tick();
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midreset");
    run_op("after-reset", 3, 3, 5, 5, 1'b0, -1, -1);

    // Start re-pulsed during COPY is ignored.
    for (int i = 0; i < N; i++) img[i] = {8'(i), 8'(8'h3F - i), 8'(i ^ 8'h15)};
    run_op("restart", 0, 7, 0, 7, 1'b0, 80, -1);

    // Inverted polarity; 0x7F equals thresh and is background. Inputs flipped mid-scan.
    for (int i = 0; i < N; i++) img[i] = 24'h7F7F7F;
    img[5*W+3] = 24'h7FFF7F;
    thresh = 8'h7F;
    invert = 1'b1;
    run_op("invert", 3, 3, 5, 5, 1'b0, -1, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
